// File: rtl/eeprom_word_assembler_pkg.sv
// eeprom_word_assembler_pkg: shared FSM state type and word width for the EEPROM word assembler.
package eeprom_word_assembler_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {IDLE, REQ, STREAM, CANCEL, DRAIN} state_t;

    function automatic logic byte_end(input logic [4:0] bit_cnt);
        return bit_cnt[2:0] == 3'd7;
    endfunction

endpackage

// File: rtl/eeprom_word_assembler_if.sv
// eeprom_word_assembler_if: EEPROM serial stream, control and word-output signals of the assembler.
interface eeprom_word_assembler_if #(parameter int LEN_W = 16);
    import eeprom_word_assembler_pkg::*;

    logic             IN_start;
    logic [LEN_W-1:0] IN_numWords;
    logic             IN_data;
    logic             IN_dataValid;
    logic             IN_dataByte;
    logic             IN_dataWord;
    logic             OUT_read;
    logic             OUT_cancel;
    logic [WORD_W-1:0] OUT_word;
    logic             OUT_wordValid;
    logic             IN_wordReady;
    logic             OUT_busy;
    logic             OUT_done;
    logic             OUT_overflow;
    logic             OUT_alignErr;

    modport master (
        output IN_start, IN_numWords, IN_data, IN_dataValid, IN_dataByte, IN_dataWord, IN_wordReady,
        input  OUT_read, OUT_cancel, OUT_word, OUT_wordValid, OUT_busy, OUT_done, OUT_overflow, OUT_alignErr
    );

    modport slave (
        input  IN_start, IN_numWords, IN_data, IN_dataValid, IN_dataByte, IN_dataWord, IN_wordReady,
        output OUT_read, OUT_cancel, OUT_word, OUT_wordValid, OUT_busy, OUT_done, OUT_overflow, OUT_alignErr
    );

endinterface

// File: rtl/eeprom_word_assembler_fifo.sv
// sync_word_fifo: synchronous FIFO with wrap-bit pointers and a registered head word.
module sync_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr, r_rptr, w_rptr_n;
    logic [WIDTH-1:0] r_rdata;
    logic             w_rd, w_wr;

    assign o_empty  = r_wptr == r_rptr;
    assign o_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd     = i_pop && !o_empty;
    assign w_wr     = i_push && (!o_full || w_rd);
    assign w_rptr_n = r_rptr + (AW+1)'(w_rd);
    assign o_rdata  = r_rdata;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    // The head register takes the incoming word when it lands in the slot about to become the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_rdata <= '0;
        end else begin
            r_wptr  <= r_wptr + (AW+1)'(w_wr);
            r_rptr  <= w_rptr_n;
            r_rdata <= (w_wr && r_wptr[AW-1:0] == w_rptr_n[AW-1:0]) ? i_wdata : r_mem[w_rptr_n[AW-1:0]];
        end
    end

endmodule

// File: rtl/eeprom_word_assembler.sv
// eeprom_word_assembler: assembles the EEPROM serial stream into 32-bit words and buffers them for a consumer.
module eeprom_word_assembler
    import eeprom_word_assembler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input logic clk,
    input logic rst,
    eeprom_word_assembler_if.slave bus
);

    state_t            r_state, w_next;
    logic [WORD_W-1:0] r_sr, w_word;
    logic [4:0]        r_bit_cnt;
    logic [LEN_W-1:0]  r_len, r_word_cnt, w_word_cnt_inc;
    logic              r_done, r_overflow, r_align_err;
    logic              w_start, w_valid, w_word_end, w_align, w_push, w_full, w_empty;

    assign w_start        = r_state == IDLE && bus.IN_start;
    assign w_valid        = r_state == STREAM && bus.IN_dataValid;
    assign w_word         = {r_sr[WORD_W-2:0], bus.IN_data};
    assign w_word_end     = w_valid && bus.IN_dataWord;
    assign w_align        = (bus.IN_dataWord && r_bit_cnt != 5'd31) || (bus.IN_dataByte != byte_end(r_bit_cnt));
    assign w_push         = w_word_end && !w_full;
    assign w_word_cnt_inc = r_word_cnt + 1'b1;

    assign bus.OUT_read      = r_state == REQ;
    assign bus.OUT_cancel    = r_state == CANCEL;
    assign bus.OUT_busy      = r_state != IDLE;
    assign bus.OUT_done      = r_done;
    assign bus.OUT_overflow  = r_overflow;
    assign bus.OUT_alignErr  = r_align_err;
    assign bus.OUT_wordValid = !w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // A full FIFO at word completion ends the transfer: the stream cannot be stalled.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = (bus.IN_start && bus.IN_numWords != '0) ? REQ : IDLE;
            REQ:     w_next = STREAM;
            STREAM:  w_next = (w_word_end && (w_full || w_word_cnt_inc == r_len)) ? CANCEL : STREAM;
            CANCEL:  w_next = DRAIN;
            DRAIN:   w_next = w_empty ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_done <= (w_start && bus.IN_numWords == '0) || (r_state == DRAIN && w_empty);
            if (w_start) begin
                r_len       <= bus.IN_numWords;
                r_bit_cnt   <= '0;
                r_word_cnt  <= '0;
                r_overflow  <= 1'b0;
                r_align_err <= 1'b0;
            end
            if (w_valid) begin
                r_sr      <= w_word;
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if (w_valid && w_align) r_align_err <= 1'b1;
            if (w_word_end && w_full) r_overflow <= 1'b1;
            if (w_push) r_word_cnt <= w_word_cnt_inc;
        end
    end

    sync_word_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (bus.IN_wordReady),
        .o_rdata (bus.OUT_word),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_eeprom_word_assembler.sv
// tb_eeprom_word_assembler: directed stream stimulus with a word scoreboard drained by a monitor process.
module tb_eeprom_word_assembler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    eeprom_word_assembler_if #(.LEN_W(16)) bus();
    eeprom_word_assembler #(.DEPTH(4), .LEN_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int n_read = 0, n_cancel = 0, n_done = 0, n_busy = 0;
    int s_read, s_cancel, s_done, s_busy;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every popped word must be the oldest expected one.
    always @(negedge clk) begin
        n_read   += int'(bus.OUT_read);
        n_cancel += int'(bus.OUT_cancel);
        n_done   += int'(bus.OUT_done);
        n_busy   += int'(bus.OUT_busy);
        if (bus.OUT_wordValid && bus.IN_wordReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_unexpected got=%h exp=none", bus.OUT_word);
            end else begin
                chk("word", bus.OUT_word, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_read = n_read; s_cancel = n_cancel; s_done = n_done; s_busy = n_busy;
    endtask

    task automatic start(input int n);
        bus.IN_start = 1'b1;
        bus.IN_numWords = 16'(n);
        tick();
        bus.IN_start = 1'b0;
        tick();
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bus.IN_data = w[n-1-i];
            bus.IN_dataValid = 1'b1;
            bus.IN_dataByte = (i % 8) == 7;
            bus.IN_dataWord = i == n - 1;
            tick();
        end
        bus.IN_dataValid = 1'b0;
        bus.IN_dataByte = 1'b0;
        bus.IN_dataWord = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            seen = bus.OUT_done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout got=0 exp=1", name);
        end
        tick();
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, 32'(bus.OUT_busy), 0);
        chk({name, "_valid"}, 32'(bus.OUT_wordValid), 0);
        chk({name, "_word"}, bus.OUT_word, 0);
        chk({name, "_read"}, 32'(bus.OUT_read), 0);
        chk({name, "_cancel"}, 32'(bus.OUT_cancel), 0);
        chk({name, "_done"}, 32'(bus.OUT_done), 0);
        chk({name, "_ovf"}, 32'(bus.OUT_overflow), 0);
        chk({name, "_align"}, 32'(bus.OUT_alignErr), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.IN_start = 0; bus.IN_numWords = 0; bus.IN_data = 0; bus.IN_dataValid = 0;
        bus.IN_dataByte = 0; bus.IN_dataWord = 0; bus.IN_wordReady = 0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        tick();
        rst = 1'b1;
        tick();

        // Two words, consumer always ready.
        snap();
        bus.IN_wordReady = 1'b1;
        start(2);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h12345678);
        send_bits(32'hDEADBEEF, 32);
        send_bits(32'h12345678, 32);
        @(negedge clk);
        chk("t1_cancel_now", 32'(bus.OUT_cancel), 1);
        wait_done("t1", 20);
        chk("t1_reads", 32'(n_read - s_read), 1);
        chk("t1_cancels", 32'(n_cancel - s_cancel), 1);
        chk("t1_dones", 32'(n_done - s_done), 1);
        chk("t1_drained", 32'(exp_q.size()), 0);
        chk("t1_ovf", 32'(bus.OUT_overflow), 0);
        chk("t1_align", 32'(bus.OUT_alignErr), 0);

        // Consumer stalled: fifth word finds the FIFO full and is dropped.
        snap();
        bus.IN_wordReady = 1'b0;
        start(6);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'hA5A5A5A5);
        exp_q.push_back(32'h0F0F0F0F);
        send_bits(32'hDEADBEEF, 32);
        send_bits(32'h12345678, 32);
        send_bits(32'hA5A5A5A5, 32);
        send_bits(32'h0F0F0F0F, 32);
        send_bits(32'hCAFEF00D, 32);
        @(negedge clk);
        chk("t2_cancel_now", 32'(bus.OUT_cancel), 1);
        chk("t2_ovf", 32'(bus.OUT_overflow), 1);
        chk("t2_valid", 32'(bus.OUT_wordValid), 1);
        repeat (5) @(negedge clk);
        chk("t2_held_done", 32'(n_done - s_done), 0);
        chk("t2_held_busy", 32'(bus.OUT_busy), 1);
        tick();
        bus.IN_wordReady = 1'b1;
        wait_done("t2", 30);
        chk("t2_dones", 32'(n_done - s_done), 1);
        chk("t2_cancels", 32'(n_cancel - s_cancel), 1);
        chk("t2_drained", 32'(exp_q.size()), 0);
        chk("t2_ovf_sticky", 32'(bus.OUT_overflow), 1);

        // Zero-length request.
        snap();
        start(0);
        chk("t3_dones", 32'(n_done - s_done), 1);
        chk("t3_reads", 32'(n_read - s_read), 0);
        chk("t3_busy", 32'(n_busy - s_busy), 0);
        chk("t3_ovf_cleared", 32'(bus.OUT_overflow), 0);

        // Early word strobe after 30 bits; two stale bits (01) remain from 0xCAFEF00D.
        snap();
        start(1);
        exp_q.push_back(32'h6AAAAAAA);
        send_bits(32'h2AAAAAAA, 30);
        @(negedge clk);
        chk("t4_align", 32'(bus.OUT_alignErr), 1);
        chk("t4_cancel_now", 32'(bus.OUT_cancel), 1);
        wait_done("t4", 20);
        chk("t4_drained", 32'(exp_q.size()), 0);
        chk("t4_ovf", 32'(bus.OUT_overflow), 0);

        // One word, then valid bits after cancel that must be ignored.
        snap();
        bus.IN_wordReady = 1'b0;
        start(1);
        @(negedge clk);
        chk("t5_align_cleared", 32'(bus.OUT_alignErr), 0);
        exp_q.push_back(32'h0BADF00D);
        send_bits(32'h0BADF00D, 32);
        bus.IN_data = 1'b1; bus.IN_dataValid = 1'b1; bus.IN_dataByte = 1'b1;
        tick();
        bus.IN_dataWord = 1'b1;
        tick();
        bus.IN_data = 1'b0; bus.IN_dataValid = 1'b0; bus.IN_dataByte = 1'b0; bus.IN_dataWord = 1'b0;
        @(negedge clk);
        chk("t5_head", bus.OUT_word, 32'h0BADF00D);
        chk("t5_valid", 32'(bus.OUT_wordValid), 1);
        chk("t5_align", 32'(bus.OUT_alignErr), 0);
        tick();
        bus.IN_wordReady = 1'b1;
        wait_done("t5", 20);
        chk("t5_drained", 32'(exp_q.size()), 0);
        chk("t5_empty", 32'(bus.OUT_wordValid), 0);
        chk("t5_reads", 32'(n_read - s_read), 1);

        // Reset mid-stream with two words buffered.
        bus.IN_wordReady = 1'b0;
        start(4);
        send_bits(32'h11111111, 32);
        send_bits(32'h22222222, 32);
        bus.IN_data = 1'b1; bus.IN_dataValid = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("t6_buffered", 32'(bus.OUT_wordValid), 1);
        tick();
        rst = 1'b0;
        bus.IN_dataValid = 1'b0;
        @(negedge clk);
        chk_idle("t6_rst");
        tick();
        rst = 1'b1;
        tick();
        snap();
        bus.IN_wordReady = 1'b1;
        start(1);
        exp_q.push_back(32'h55AA33CC);
        send_bits(32'h55AA33CC, 32);
        wait_done("t6", 20);
        chk("t6_reads", 32'(n_read - s_read), 1);
        chk("t6_dones", 32'(n_done - s_done), 1);
        chk("t6_drained", 32'(exp_q.size()), 0);
        chk("t6_align", 32'(bus.OUT_alignErr), 0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
